// File: rtl/nor_reader.sv
// QSPI NOR read initiator: one 32-bit little-endian word per request in 1-1-1, 2-2-2 or 4-4-4 mode.
// Define NOR_READER_BURST_EN to keep csb low after a read and stream a sequential follow-on word.
module nor_reader #(
  parameter logic [7:0]  CMD_SPI   = 8'h0B,
  parameter logic [7:0]  CMD_DPI   = 8'hBB,
  parameter logic [7:0]  CMD_QPI   = 8'hEB,
  parameter int unsigned DUMMY_SPI = 8,
  parameter int unsigned DUMMY_DPI = 8,
  parameter int unsigned DUMMY_QPI = 10,
  parameter int unsigned CSB_HIGH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  mode_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        sck_o,
  output logic        csb_o,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oe_o,
  input  logic [3:0]  sio_i
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StGap, StHold} state_e;

  localparam logic [1:0] ModeSpi = 2'd0;
  localparam logic [1:0] ModeDpi = 2'd1;
  localparam logic [1:0] ModeQpi = 2'd2;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;  // current sck level while a phase is running
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ready_q, ready_d;
  logic [1:0]  mode_sel;
  logic        handshake;

  // SCK cycles minus one spent in a phase for a given mode.
  function automatic logic [5:0] phase_len(input state_e st, input logic [1:0] m);
    logic [5:0] n;
    n = 6'd1;
    case (st)
      StCmd:   n = (m == ModeQpi) ? 6'd2 : (m == ModeDpi) ? 6'd4 : 6'd8;
      StAddr:  n = (m == ModeQpi) ? 6'd6 : (m == ModeDpi) ? 6'd12 : 6'd24;
      StDummy: n = (m == ModeQpi) ? 6'(DUMMY_QPI) : (m == ModeDpi) ? 6'(DUMMY_DPI) : 6'(DUMMY_SPI);
      StData:  n = (m == ModeQpi) ? 6'd8 : (m == ModeDpi) ? 6'd16 : 6'd32;
      default: n = 6'd1;
    endcase
    return n - 6'd1;
  endfunction

  assign mode_sel = (mode_i == 2'd3) ? ModeSpi : mode_i;

`ifdef NOR_READER_BURST_EN
  logic burst_match;
  assign burst_match = (req_addr_i == addr_q + 24'd4) && (mode_sel == mode_q);
  assign req_ready_o = ready_q | ((state_q == StHold) & req_valid_i & burst_match);
`else
  assign req_ready_o = ready_q;
`endif

  assign handshake = req_valid_i & req_ready_o;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StCmd;
          phase_d = 1'b0;
          mode_d  = mode_sel;
          addr_d  = req_addr_i;
          cnt_d   = phase_len(StCmd, mode_sel);
          unique case (mode_sel)
            ModeDpi: tx_d = {CMD_DPI, req_addr_i};
            ModeQpi: tx_d = {CMD_QPI, req_addr_i};
            default: tx_d = {CMD_SPI, req_addr_i};
          endcase
        end
      end
      StCmd, StAddr, StDummy, StData: begin
        phase_d = ~phase_q;
        // Shift on the edge ending the high half, i.e. the falling sck edge.
        if (phase_q) begin
          if (state_q inside {StCmd, StAddr}) begin
            unique case (mode_q)
              ModeDpi: tx_d = {tx_q[29:0], 2'b00};
              ModeQpi: tx_d = {tx_q[27:0], 4'b0000};
              default: tx_d = {tx_q[30:0], 1'b0};
            endcase
          end
          if (state_q == StData) begin
            unique case (mode_q)
              ModeDpi: rx_d = {rx_q[29:0], sio_i[1:0]};
              ModeQpi: rx_d = {rx_q[27:0], sio_i};
              default: rx_d = {rx_q[30:0], sio_i[1]};
            endcase
          end
          if (cnt_q == 6'd0) begin
            unique case (state_q)
              StCmd: begin
                state_d = StAddr;
                cnt_d   = phase_len(StAddr, mode_q);
              end
              StAddr: begin
                state_d = StDummy;
                cnt_d   = phase_len(StDummy, mode_q);
              end
              StDummy: begin
                state_d = StData;
                cnt_d   = phase_len(StData, mode_q);
              end
              default: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
`ifdef NOR_READER_BURST_EN
                state_d = StHold;
                cnt_d   = 6'd15;
`else
                state_d = StGap;
                cnt_d   = 6'(CSB_HIGH - 1);
`endif
              end
            endcase
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      StGap: begin
        if (cnt_q == 6'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 6'd1;
      end
`ifdef NOR_READER_BURST_EN
      StHold: begin
        if (handshake) begin
          state_d = StData;
          phase_d = 1'b0;
          addr_d  = req_addr_i;
          cnt_d   = phase_len(StData, mode_q);
        end else if (req_valid_i || cnt_q == 6'd0) begin
          state_d = StGap;
          cnt_d   = 6'(CSB_HIGH - 1);
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign ready_d = (state_d == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign sck_o       = phase_q & (state_q inside {StCmd, StAddr, StDummy, StData});
  assign csb_o       = ~(state_q inside {StCmd, StAddr, StDummy, StData, StHold});

  always_comb begin
    sio_o    = 4'b0000;
    sio_oe_o = 4'b0000;
    if (state_q inside {StCmd, StAddr}) begin
      unique case (mode_q)
        ModeDpi: begin
          sio_o    = {2'b00, tx_q[31:30]};
          sio_oe_o = 4'b0011;
        end
        ModeQpi: begin
          sio_o    = tx_q[31:28];
          sio_oe_o = 4'b1111;
        end
        default: begin
          sio_o    = {2'b11, 1'b0, tx_q[31]};
          sio_oe_o = 4'b1101;
        end
      endcase
    end else if (state_q inside {StDummy, StData, StHold}) begin
      // WP#/HOLD# stay driven high for the whole single-lane transaction.
      if (mode_q != ModeDpi && mode_q != ModeQpi) begin
        sio_o    = 4'b1100;
        sio_oe_o = 4'b1100;
      end
    end
  end

endmodule
